i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one i2c_master.
REQ-002 Parameter TIMEOUT, default 4096: maximum cycles spent in START or XFER before the transfer is aborted.
REQ-003 Port clk, in, 1: single clock; all logic on posedge clk.
REQ-004 Port rst, in, 1: reset, synchronous and active-high.
REQ-005 Port req, in, NREQ: per-requester transfer request level.
REQ-006 Port req_addr, in, 7*NREQ: 7-bit slave address; requester k uses bits [7k+6:7k].
REQ-007 Port req_op, in, NREQ: per-requester operation; 0 = write, 1 = read.
REQ-008 Port req_wdata, in, 8*NREQ: write byte; requester k uses bits [8k+7:8k].
REQ-009 Port gnt, out, NREQ: one-hot grant, high from START entry through XFER.
REQ-010 Port done, out, NREQ: one-cycle completion pulse to the granted requester.
REQ-011 Port rdata, out, 8: read byte, valid in the done cycle.
REQ-012 Port err, out, 1: ack error or timeout, valid in the done cycle.
REQ-013 Ports to the i2c_master:
- m_newd, out, 1
- m_addr, out, 7
- m_op, out, 1
- m_din, out, 8
- m_dout, in, 8
- m_busy, in, 1
- m_ack_err, in, 1

Function
REQ-014 The FSM SHALL have four states: IDLE, START, XFER, DONE.
REQ-015 In IDLE with any req bit set, the arbiter SHALL select the winner round-robin, searching ptr+1 .. ptr modulo NREQ, where ptr is the last served index.
REQ-016 On selection, the arbiter SHALL, in the same clock edge:
- latch the winner's addr/op/wdata into m_addr/m_op/m_din
- store the winner's index
- enter START
REQ-017 Latency: a req sampled in IDLE in cycle N SHALL produce gnt, m_newd=1 and valid m_addr in cycle N+1.
REQ-018 In START, m_newd SHALL be 1.
REQ-019 When m_busy is sampled 1 in START, the FSM SHALL enter XFER, with m_newd 0 from the next cycle.
REQ-020 In XFER, the FSM SHALL wait for m_busy sampled 0, then capture m_dout into rdata and m_ack_err into err, and enter DONE.
REQ-021 m_addr, m_op and m_din SHALL hold stable from START entry until the next selection.
REQ-022 A cycle counter SHALL clear on every START or XFER entry and increment each cycle in those states.
REQ-023 When the counter reaches TIMEOUT-1 without the exit condition, the FSM SHALL enter DONE with err=1 and rdata=0.
REQ-024 In DONE, for exactly one cycle:
- done[idx] = 1
- gnt = 0
- m_newd = 0
- ptr <= idx
- next state IDLE
REQ-025 Deassertion of req during START or XFER SHALL be ignored; the transfer completes and done still pulses.
REQ-026 req is only sampled in IDLE; a requester that holds req after its done is re-arbitrated, and other pending requesters win first.
REQ-027 Changes on req_addr/req_op/req_wdata after selection SHALL have no effect on the current transfer.
REQ-028 Outputs not asserted by the current state SHALL be 0; rdata and err are meaningful only when a done bit is 1.

Reset
REQ-029 When rst is 1 at a clock edge, in any state, the arbiter SHALL enter IDLE, clear the counter, and set ptr = NREQ-1 so requester 0 has first priority.
REQ-030 During reset, all outputs SHALL be 0: gnt, done, rdata, err, m_newd, m_addr, m_op, m_din.
REQ-031 A reset during START or XFER SHALL abort without any done pulse.

Verification
REQ-032 Write: req[0]=1, addr 7'h78, op 0, wdata 8'hFF; master model raises busy 2 cycles after newd and drops it 30 cycles later with ack_err 0 -> m_addr=0x78 and m_din=0xFF stable, single done[0] pulse, err 0.
REQ-033 Contention: req=4'b1111 held from reset release -> grant order 0,1,2,3,0, and gnt is never multi-hot.
REQ-034 Read: req[2]=1, op 1; model returns dout 8'hA5 -> rdata=0xA5 with done[2], err 0.
REQ-035 NACK: model sets ack_err=1 at busy fall -> done pulse with err=1.
REQ-036 Timeout: model never raises busy -> TIMEOUT cycles after START entry, done with err=1, rdata 0, m_newd 0.
REQ-037 Reset mid-transfer: rst in XFER -> next cycle all outputs 0 and no done; then req[3] and req[0] together -> requester 0 served first.

Source files
------------

// File: rtl/i2c_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_arbiter
//
// Shares one i2c_master between NREQ requesters. A round-robin pick is made
// in IDLE, the winner's address/op/write byte are latched towards the
// master, and the FSM walks START -> XFER -> DONE. A per-state cycle
// counter aborts a stuck transfer after TIMEOUT cycles with err=1.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   req           : per-requester request level (sampled only in IDLE)
//   req_addr      : 7-bit address per requester, packed [7k+6:7k]
//   req_op        : per-requester op, 0 = write, 1 = read
//   req_wdata     : write byte per requester, packed [8k+7:8k]
//   gnt           : one-hot grant, high in START and XFER
//   done          : one-cycle completion pulse to the served requester
//   rdata, err    : read byte / error flag, valid only while done != 0
//   m_newd        : new-transfer strobe to the master (high in START)
//   m_addr/op/din : latched transfer parameters to the master
//   m_dout        : read byte from the master
//   m_busy        : master busy flag
//   m_ack_err     : master acknowledge error
// ---------------------------------------------------------------------------
module i2c_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [NREQ-1:0]      req_op,
    input  logic [8*NREQ-1:0]    req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [7:0]           rdata,
    output logic                 err,
    output logic                 m_newd,
    output logic [6:0]           m_addr,
    output logic                 m_op,
    output logic [7:0]           m_din,
    input  logic [7:0]           m_dout,
    input  logic                 m_busy,
    input  logic                 m_ack_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [6:0]      addr_reg, addr_next;
    logic            op_reg, op_next;
    logic [7:0]      din_reg, din_next;
    logic [7:0]      rdata_reg, rdata_next;
    logic            err_reg, err_next;

    // Unpacked views of the per-requester buses.
    logic [6:0]      addr_arr  [NREQ];
    logic [7:0]      wdata_arr [NREQ];

    logic            active;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   win_c;

    assign active = (state_reg == START) || (state_reg == XFER);

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_addr[7*gi +: 7];
            assign wdata_arr[gi] = req_wdata[8*gi +: 8];
            assign gnt[gi]       = active && (idx_reg == IW'(gi));
            assign done[gi]      = (state_reg == DONE) && (idx_reg == IW'(gi));
        end
    endgenerate

    // Round-robin search: candidates ptr+1, ptr+2, ... wrapping, ending at ptr.
    // The explicit wrap keeps this correct for non-power-of-two NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_c     = ptr_reg;
        for (int i = 0; i < NREQ; i++) begin
            win_c = (win_c == IDX_LAST) ? '0 : win_c + IW'(1);
            if (!win_found && req[win_c]) begin
                win_found = 1'b1;
                win_idx   = win_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            ptr_reg   <= IDX_LAST;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            op_reg    <= 1'b0;
            din_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            op_reg    <= op_next;
            din_reg   <= din_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        op_next    = op_reg;
        din_next   = din_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    // Parameters are captured here and never re-read, so later
                    // changes on the request buses cannot disturb the transfer.
                    idx_next   = win_idx;
                    addr_next  = addr_arr[win_idx];
                    op_next    = req_op[win_idx];
                    din_next   = wdata_arr[win_idx];
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (m_busy) begin
                    cnt_next   = '0;
                    state_next = XFER;
                end else if (cnt_reg == CNT_LAST) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            XFER: begin
                if (!m_busy) begin
                    rdata_next = m_dout;
                    err_next   = m_ack_err;
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                ptr_next   = idx_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign m_newd = (state_reg == START);
    assign m_addr = addr_reg;
    assign m_op   = op_reg;
    assign m_din  = din_reg;
    // Result registers may hold stale values between transfers; only expose
    // them alongside the done pulse.
    assign rdata  = (state_reg == DONE) ? rdata_reg : 8'h00;
    assign err    = (state_reg == DONE) ? err_reg : 1'b0;

endmodule

// File: tb/tb_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_arbiter
//
// Self-checking bench for i2c_arbiter. A behavioural i2c_master model answers
// m_newd with a configurable busy window. Expected transactions are pushed
// to a scoreboard queue when requests are driven; a negedge monitor checks
// grant/latched parameters while granted and pops/compares on each done.
// ---------------------------------------------------------------------------
module tb_i2c_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [7*NREQ-1:0] req_addr = '0;
    logic [NREQ-1:0]   req_op = '0;
    logic [8*NREQ-1:0] req_wdata = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        rdata;
    logic              err;
    logic              m_newd;
    logic [6:0]        m_addr;
    logic              m_op;
    logic [7:0]        m_din;
    logic [7:0]        m_dout;
    logic              m_busy = 1'b0;
    logic              m_ack_err = 1'b0;

    always #5 clk = ~clk;

    i2c_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_op    (req_op),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .m_newd    (m_newd),
        .m_addr    (m_addr),
        .m_op      (m_op),
        .m_din     (m_din),
        .m_dout    (m_dout),
        .m_busy    (m_busy),
        .m_ack_err (m_ack_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- master model ----------------
    int         mdl_delay = 2;
    int         mdl_len   = 30;
    logic       mdl_ack   = 1'b0;
    logic       mdl_never = 1'b0;
    logic [7:0] mdl_dout  = 8'h00;
    int         mst  = 0;
    int         mcnt = 0;

    assign m_dout = mdl_dout;

    always @(posedge clk) begin
        if (rst) begin
            mst       <= 0;
            mcnt      <= 0;
            m_busy    <= 1'b0;
            m_ack_err <= 1'b0;
        end else begin
            case (mst)
                0: if (m_newd && !mdl_never) begin mcnt <= 1; mst <= 1; end
                1: if (mcnt >= mdl_delay) begin
                       m_busy <= 1'b1; m_ack_err <= 1'b0; mcnt <= 1; mst <= 2;
                   end else mcnt <= mcnt + 1;
                2: if (mcnt >= mdl_len) begin
                       m_busy <= 1'b0; m_ack_err <= mdl_ack; mst <= 3;
                   end else mcnt <= mcnt + 1;
                default: mst <= 0;
            endcase
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        int         idx;
        logic [6:0] addr;
        logic       op;
        logic [7:0] din;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   done_seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (gnt != 0) begin
                if (exp_q.size() == 0) begin
                    check("gnt_unexpected", 32'(gnt), 32'd0);
                end else begin
                    check("gnt_idx", 32'(gnt), 32'd1 << exp_q[0].idx);
                    check("m_addr_hold", 32'(m_addr), 32'(exp_q[0].addr));
                    check("m_op_hold", 32'(m_op), 32'(exp_q[0].op));
                    check("m_din_hold", 32'(m_din), 32'(exp_q[0].din));
                end
            end
            if (done != 0) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_idx", 32'(done), 32'd1 << mon_e.idx);
                    check("done_err", 32'(err), 32'(mon_e.err));
                    check("done_rdata", 32'(rdata), 32'(mon_e.rdata));
                    check("done_gnt_low", 32'(gnt), 32'd0);
                    check("done_newd_low", 32'(m_newd), 32'd0);
                    $display("[TB] txn idx=%0d addr=%02h op=%0d err=%0d rdata=%02h",
                             mon_e.idx, mon_e.addr, mon_e.op, err, rdata);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_exp(input int idx, input logic [6:0] a, input logic o,
                            input logic [7:0] d, input logic e, input logic [7:0] r);
        exp_t x;
        x.idx = idx; x.addr = a; x.op = o; x.din = d; x.err = e; x.rdata = r;
        exp_q.push_back(x);
    endtask

    task automatic set_model(input int dly, input int len, input logic ack,
                             input logic [7:0] dout, input logic never);
        mdl_delay = dly; mdl_len = len; mdl_ack = ack; mdl_dout = dout; mdl_never = never;
    endtask

    task automatic scramble();
        req_addr  = 28'($urandom);
        req_wdata = $urandom;
        req_op    = 4'($urandom);
    endtask

    task automatic wait_gnt(input string name);
        int n;
        n = 0;
        while (gnt == 0 && n < 20) begin @(negedge clk); n++; end
        check(name, 32'(gnt != 0), 32'd1);
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (done_seen < target && n < budget) begin @(negedge clk); n++; end
        check(name, 32'(done_seen), 32'(target));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         idx;
        logic [6:0] addr;
        logic       op;
        logic [7:0] wdata;
        int         dly;
        int         len;
        logic       ack;
        logic [7:0] dout;
        logic       never;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int target;
        set_model(v.dly, v.len, v.ack, v.dout, v.never);
        push_exp(v.idx, v.addr, v.op, v.wdata, v.exp_err, v.exp_rdata);
        target = done_seen + 1;
        @(negedge clk);
        scramble();
        req_addr[7*v.idx +: 7]  = v.addr;
        req_wdata[8*v.idx +: 8] = v.wdata;
        req_op[v.idx]           = v.op;
        req = 4'b0001 << v.idx;
        wait_gnt("vec_gnt");
        req = '0;
        scramble();          // must not affect the latched transfer
        wait_done("vec_done", target, 3 * TIMEOUT);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        int n;

        //           idx addr   op wdata  dly len ack  dout   never err  rdata
        vecs[0] = '{0, 7'h78, 1'b0, 8'hFF, 2, 30, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{2, 7'h50, 1'b1, 8'h00, 2, 30, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5};
        vecs[2] = '{1, 7'h2A, 1'b0, 8'h3C, 1,  5, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[3] = '{3, 7'h11, 1'b1, 8'h00, 2, 30, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00};
        vecs[4] = '{0, 7'h7F, 1'b1, 8'h00, 3,  1, 1'b0, 8'h81, 1'b0, 1'b0, 8'h81};
        vecs[5] = '{3, 7'h01, 1'b0, 8'h80, 2,  8, 1'b1, 8'h5E, 1'b0, 1'b1, 8'h5E};

        // ---- reset state, with all four requests already pending ----
        rst = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            req_addr[7*k +: 7]  = 7'(7'h10 + k);
            req_wdata[8*k +: 8] = 8'(8'h20 + k);
        end
        req_op = '0;
        req    = 4'b1111;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_newd", 32'(m_newd), 32'd0);
        check("rst_addr", 32'(m_addr), 32'd0);
        check("rst_op", 32'(m_op), 32'd0);
        check("rst_din", 32'(m_din), 32'd0);

        // ---- contention: expect 0,1,2,3,0 ----
        set_model(1, 3, 1'b0, 8'h3C, 1'b0);
        push_exp(0, 7'h10, 1'b0, 8'h20, 1'b0, 8'h3C);
        push_exp(1, 7'h11, 1'b0, 8'h21, 1'b0, 8'h3C);
        push_exp(2, 7'h12, 1'b0, 8'h22, 1'b0, 8'h3C);
        push_exp(3, 7'h13, 1'b0, 8'h23, 1'b0, 8'h3C);
        push_exp(0, 7'h10, 1'b0, 8'h20, 1'b0, 8'h3C);
        base = done_seen;
        rst = 1'b0;
        wait_done("rr_done", base + 5, 400);
        req = '0;
        repeat (4) @(negedge clk);
        check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---- table vectors ----
        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // ---- latency: req in cycle N -> gnt/newd/addr in N+1; newd drops after busy ----
        set_model(2, 10, 1'b0, 8'h6B, 1'b0);
        push_exp(2, 7'h33, 1'b1, 8'h44, 1'b0, 8'h6B);
        base = done_seen;
        @(negedge clk);
        req_addr[14 +: 7]  = 7'h33;
        req_wdata[16 +: 8] = 8'h44;
        req_op[2]          = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        check("lat_gnt", 32'(gnt), 32'h4);
        check("lat_newd", 32'(m_newd), 32'd1);
        check("lat_addr", 32'(m_addr), 32'h33);
        req = '0;
        n = 0;
        while (!m_busy && n < 20) begin @(negedge clk); n++; end
        check("lat_busy_seen", 32'(m_busy), 32'd1);
        @(negedge clk);
        check("xfer_newd_low", 32'(m_newd), 32'd0);
        check("xfer_gnt", 32'(gnt), 32'h4);
        wait_done("lat_done", base + 1, 100);
        repeat (3) @(negedge clk);

        // ---- timeout: busy never rises ----
        set_model(2, 30, 1'b0, 8'h99, 1'b1);
        push_exp(1, 7'h45, 1'b1, 8'h00, 1'b1, 8'h00);
        @(negedge clk);
        req_addr[7 +: 7]  = 7'h45;
        req_wdata[8 +: 8] = 8'h00;
        req_op[1]         = 1'b1;
        req = 4'b0010;
        wait_gnt("to_gnt");
        req = '0;
        n = 0;
        while (done == 0 && n < TIMEOUT + 10) begin @(negedge clk); n++; end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("timeout_newd", 32'(m_newd), 32'd0);
        repeat (3) @(negedge clk);
        mdl_never = 1'b0;

        // ---- reset in XFER: outputs clear, no done; then 0 beats 3 ----
        set_model(1, 40, 1'b0, 8'h12, 1'b0);
        push_exp(2, 7'h66, 1'b0, 8'h77, 1'b0, 8'h12);
        @(negedge clk);
        req_addr[14 +: 7]  = 7'h66;
        req_wdata[16 +: 8] = 8'h77;
        req_op[2]          = 1'b0;
        req = 4'b0100;
        wait_gnt("rx_gnt");
        req = '0;
        n = 0;
        while (!(m_busy && !m_newd && gnt != 0) && n < 30) begin @(negedge clk); n++; end
        check("rx_in_xfer", 32'(m_busy && !m_newd && gnt != 0), 32'd1);
        @(negedge clk);
        base = done_seen;
        rst = 1'b1;
        @(negedge clk);
        check("rx_gnt", 32'(gnt), 32'd0);
        check("rx_done", 32'(done), 32'd0);
        check("rx_rdata", 32'(rdata), 32'd0);
        check("rx_err", 32'(err), 32'd0);
        check("rx_newd", 32'(m_newd), 32'd0);
        check("rx_addr", 32'(m_addr), 32'd0);
        check("rx_op", 32'(m_op), 32'd0);
        check("rx_din", 32'(m_din), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        set_model(1, 4, 1'b0, 8'h0F, 1'b0);
        req_addr[0 +: 7]   = 7'h0A;
        req_wdata[0 +: 8]  = 8'hB0;
        req_op[0]          = 1'b0;
        req_addr[21 +: 7]  = 7'h3B;
        req_wdata[24 +: 8] = 8'hB3;
        req_op[3]          = 1'b1;
        push_exp(0, 7'h0A, 1'b0, 8'hB0, 1'b0, 8'h0F);
        push_exp(3, 7'h3B, 1'b1, 8'hB3, 1'b0, 8'h0F);
        req = 4'b1001;
        check("rx_no_abort_done", 32'(done_seen), 32'(base));
        wait_done("rx_first", base + 1, 100);
        req[0] = 1'b0;
        wait_done("rx_second", base + 2, 100);
        req = '0;
        repeat (4) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
